// File: rtl/message_sequencer.sv
// message_sequencer: streams characters from one of four message ROMs to the
// display driver over a valid/ready handshake. A message is sent once or repeated.
// An optional dwell gap is inserted after every accepted character.
//
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   start, msg_sel, loop_en    begin a message (honoured only in IDLE)
//   abort                      synchronous return to IDLE, no done pulse
//   rom_char_0..3, rom_len_0..3  ROM character outputs / last-character index
//   counter_caracter           character index broadcast to all ROMs
//   char_out, char_valid, char_ready  character stream handshake
//   busy, done                 activity flag / end-of-message pulse
module message_sequencer #(
  parameter int unsigned DWELL_CYCLES = 4,
  parameter int unsigned DWELL_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] msg_sel,
  input  logic       loop_en,
  input  logic       abort,
  input  logic [3:0] rom_char_0,
  input  logic [3:0] rom_char_1,
  input  logic [3:0] rom_char_2,
  input  logic [3:0] rom_char_3,
  input  logic [3:0] rom_len_0,
  input  logic [3:0] rom_len_1,
  input  logic [3:0] rom_len_2,
  input  logic [3:0] rom_len_3,
  output logic [3:0] counter_caracter,
  output logic [3:0] char_out,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       busy,
  output logic       done
);

  localparam int unsigned IDX_W = 4;
  localparam bit HAS_DWELL = (DWELL_CYCLES != 0);
  // Terminal dwell count; unused when there is no dwell gap.
  localparam logic [DWELL_W-1:0] DWELL_LAST =
    DWELL_W'((DWELL_CYCLES == 0) ? 0 : DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, DWELL, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         sel_q, sel_d;
  logic [IDX_W-1:0]   len_q, len_d;
  logic               loop_q, loop_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               valid_q, busy_q, done_q;
  logic [3:0]         start_len;
  logic [3:0]         sel_char;
  state_t             after_char;

  // Length of the ROM being requested by start.
  always_comb begin
    start_len = rom_len_0;
    case (msg_sel)
      2'd1:    start_len = rom_len_1;
      2'd2:    start_len = rom_len_2;
      2'd3:    start_len = rom_len_3;
      default: start_len = rom_len_0;
    endcase
  end

  // Character of the latched ROM at the current index.
  always_comb begin
    sel_char = rom_char_0;
    case (sel_q)
      2'd1:    sel_char = rom_char_1;
      2'd2:    sel_char = rom_char_2;
      2'd3:    sel_char = rom_char_3;
      default: sel_char = rom_char_0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sel_d      = sel_q;
    len_d      = len_q;
    loop_d     = loop_q;
    dwell_d    = dwell_q;
    after_char = HAS_DWELL ? DWELL : SEND;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          sel_d   = msg_sel;
          loop_d  = loop_en;
          len_d   = start_len;
          idx_d   = '0;
          dwell_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (valid_q && char_ready) begin
          if (idx_q < len_q) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = after_char;
          end else if (!loop_q) begin
            state_d = DONE;
          end else begin
            idx_d   = '0;
            state_d = after_char;
          end
        end
      end
      DWELL: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          state_d = SEND;
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides everything, including a same-cycle handshake.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      idx_d   = '0;
      dwell_d = '0;
    end
  end

  // State and registered outputs, derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sel_q   <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      dwell_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      dwell_q <= dwell_d;
      valid_q <= (state_d == SEND);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign counter_caracter = idx_q;
  assign char_valid       = valid_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign char_out         = (state_q == SEND) ? sel_char : 4'd0;

endmodule

// File: tb/tb_message_sequencer.sv
// Bench for message_sequencer: two instances (dwell 4 and dwell 0) share the
// stimulus; one is observed at a time against a message-level expectation built
// from the ROM contents, the latched length and the dwell gap.
module tb_message_sequencer;

  localparam int unsigned DW = 4;

  logic       clk = 1'b0;
  logic       reset, start, loop_en, abort, char_ready;
  logic [1:0] msg_sel;
  logic [3:0] rom [4][16];
  logic [3:0] rom_len [4];
  logic [3:0] cnt4, cnt0, ch4, ch0;
  logic       v4, v0, b4, b0, d4, d0;
  logic [3:0] o_cnt, o_char;
  logic       o_valid, o_busy, o_done;
  bit         use0;
  int         n_assert = 0;
  int         n_fail = 0;
  int         m_sel;

  always #5 clk = ~clk;

  message_sequencer #(.DWELL_CYCLES(DW), .DWELL_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .msg_sel(msg_sel), .loop_en(loop_en),
    .abort(abort),
    .rom_char_0(rom[0][cnt4]), .rom_char_1(rom[1][cnt4]),
    .rom_char_2(rom[2][cnt4]), .rom_char_3(rom[3][cnt4]),
    .rom_len_0(rom_len[0]), .rom_len_1(rom_len[1]),
    .rom_len_2(rom_len[2]), .rom_len_3(rom_len[3]),
    .counter_caracter(cnt4), .char_out(ch4), .char_valid(v4),
    .char_ready(char_ready), .busy(b4), .done(d4)
  );

  message_sequencer #(.DWELL_CYCLES(0), .DWELL_W(8)) dut0 (
    .clk(clk), .reset(reset), .start(start), .msg_sel(msg_sel), .loop_en(loop_en),
    .abort(abort),
    .rom_char_0(rom[0][cnt0]), .rom_char_1(rom[1][cnt0]),
    .rom_char_2(rom[2][cnt0]), .rom_char_3(rom[3][cnt0]),
    .rom_len_0(rom_len[0]), .rom_len_1(rom_len[1]),
    .rom_len_2(rom_len[2]), .rom_len_3(rom_len[3]),
    .counter_caracter(cnt0), .char_out(ch0), .char_valid(v0),
    .char_ready(char_ready), .busy(b0), .done(d0)
  );

  assign o_cnt   = use0 ? cnt0 : cnt4;
  assign o_char  = use0 ? ch0  : ch4;
  assign o_valid = use0 ? v0   : v4;
  assign o_busy  = use0 ? b0   : b4;
  assign o_done  = use0 ? d0   : d4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // idx < 0 skips the index check (index is don't-care in IDLE after done).
  task automatic expect_out(input string tag, input bit v, input int idx,
                            input bit b, input bit d);
    chk({tag, "_valid"}, 32'(o_valid), 32'(v));
    chk({tag, "_busy"},  32'(o_busy),  32'(b));
    chk({tag, "_done"},  32'(o_done),  32'(d));
    if (idx >= 0) chk({tag, "_idx"}, 32'(o_cnt), 32'(idx));
    chk({tag, "_char"}, 32'(o_char), v ? 32'(rom[m_sel][idx]) : 32'd0);
  endtask

  task automatic quiesce();
    abort = 1'b1; start = 1'b0; char_ready = 1'b0;
    @(negedge clk);
    abort = 1'b0;
  endtask

  // Starts a message and follows n_acc accepted characters. Returns at the
  // negedge after IDLE is re-entered (non-looping, complete) or at the negedge
  // where the next character is being offered.
  task automatic send_msg(input int sel, input bit lp, input int n_acc, input int max_stall,
                          input int stall_idx, input int stall_n, input bit shuffle);
    int len, idx, stall, dw;
    bit last;
    dw    = use0 ? 0 : int'(DW);
    len   = int'(rom_len[sel]);
    m_sel = sel;
    start = 1'b1; msg_sel = 2'(sel); loop_en = lp; char_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (shuffle) for (int r = 0; r < 4; r++) rom_len[r] = 4'($urandom);
    for (int k = 0; k < n_acc; k++) begin
      idx   = k % (len + 1);
      stall = (idx == stall_idx) ? stall_n : int'($urandom_range(max_stall, 0));
      for (int s = 0; s < stall; s++) begin
        char_ready = 1'b0;
        expect_out("stall", 1'b1, idx, 1'b1, 1'b0);
        @(negedge clk);
      end
      char_ready = 1'b1;
      expect_out("offer", 1'b1, idx, 1'b1, 1'b0);
      last = (idx == len);
      @(negedge clk);
      char_ready = 1'($urandom_range(1, 0));
      if (last && !lp) begin
        expect_out("done", 1'b0, len, 1'b1, 1'b1);
        @(negedge clk);
        expect_out("idle", 1'b0, -1, 1'b0, 1'b0);
        char_ready = 1'b0;
        return;
      end
      for (int g = 0; g < dw; g++) begin
        expect_out("gap", 1'b0, last ? 0 : idx + 1, 1'b1, 1'b0);
        @(negedge clk);
        char_ready = 1'($urandom_range(1, 0));
      end
    end
    char_ready = 1'b0;
  endtask

  initial begin
    int sel, n;
    bit lp;
    reset = 1'b1; start = 1'b0; loop_en = 1'b0; abort = 1'b0; char_ready = 1'b0;
    msg_sel = 2'd0; use0 = 1'b0; m_sel = 0;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 16; i++) rom[k][i] = 4'($urandom);
    rom[0][0] = 4'h0; rom[0][1] = 4'h1; rom[0][2] = 4'h3;
    rom[0][3] = 4'h4; rom[0][4] = 4'hA; rom[0][5] = 4'h7;
    rom[1][0] = 4'h9; rom[2][0] = 4'h5;
    rom_len[0] = 4'd5; rom_len[1] = 4'd1; rom_len[2] = 4'd0; rom_len[3] = 4'd15;

    #3;
    expect_out("rst4", 1'b0, 0, 1'b0, 1'b0);
    use0 = 1'b1;
    expect_out("rst0", 1'b0, 0, 1'b0, 1'b0);
    use0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // ACEITO message, always ready, then with a 3-cycle stall on index 2.
    send_msg(0, 1'b0, 6, 0, -1, 0, 1'b0);
    quiesce();
    send_msg(0, 1'b0, 6, 0, 2, 3, 1'b0);

    // Async reset mid-SEND, then a normal restart.
    quiesce();
    send_msg(0, 1'b0, 2, 0, -1, 0, 1'b0);
    expect_out("pre_rst", 1'b1, 2, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 expect_out("rst_async", 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_msg(0, 1'b0, 6, 1, -1, 0, 1'b0);

    // Looping len-1 message without dwell, then abort.
    quiesce();
    use0 = 1'b1;
    send_msg(1, 1'b1, 10, 0, -1, 0, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    expect_out("loop_abort", 1'b0, 0, 1'b0, 1'b0);
    use0 = 1'b0;

    // One-character message; a start while busy must be ignored.
    quiesce();
    m_sel = 2;
    start = 1'b1; msg_sel = 2'd2; loop_en = 1'b0; char_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    expect_out("len0_a", 1'b1, 0, 1'b1, 1'b0);
    start = 1'b1; msg_sel = 2'd1; loop_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    expect_out("len0_ign", 1'b1, 0, 1'b1, 1'b0);
    char_ready = 1'b1;
    @(negedge clk);
    char_ready = 1'b0;
    expect_out("len0_done", 1'b0, 0, 1'b1, 1'b1);
    @(negedge clk);
    expect_out("len0_idle", 1'b0, -1, 1'b0, 1'b0);

    // Abort together with a handshake on index 3, then restart from index 0.
    quiesce();
    send_msg(0, 1'b0, 3, 0, -1, 0, 1'b0);
    expect_out("pre_abort", 1'b1, 3, 1'b1, 1'b0);
    char_ready = 1'b1; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; char_ready = 1'b0;
    expect_out("abort_hs", 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("abort_nodone", 1'b0, 0, 1'b0, 1'b0);
    send_msg(0, 1'b0, 6, 0, -1, 0, 1'b0);

    // Full 16-character message with rom_len disturbed mid-message.
    quiesce();
    send_msg(3, 1'b0, 16, 1, -1, 0, 1'b1);

    // Randomized messages on both instances.
    for (int it = 0; it < 14; it++) begin
      quiesce();
      use0 = 1'($urandom_range(1, 0));
      sel  = int'($urandom_range(3, 0));
      lp   = 1'($urandom_range(1, 0));
      n    = lp ? int'($urandom_range(20, 1)) : int'(rom_len[sel]) + 1;
      send_msg(sel, lp, n, 2, -1, 0, 1'b1);
      if (lp) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        expect_out("rnd_abort", 1'b0, 0, 1'b0, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/message_sequencer.md
Name: message_sequencer

Overview:
Controller that sequences the character ROMs ("aceito" and its sibling message ROMs) into the display character path. It drives the shared character index, selects one of four message ROMs, and streams characters to the display driver through a valid/ready handshake. Each message is transmitted once, or repeats with a dwell gap between characters and between passes.

Parameters:
DWELL_CYCLES, 4, idle cycles inserted after each accepted character before the next is offered; 0 = no gap
DWELL_W, 8, width of the dwell counter; DWELL_CYCLES must be < 2^DWELL_W

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a message; honoured only in IDLE
msg_sel  input  2  message ROM select (0..3), sampled with start
loop_en  input  1  1 = repeat message after last char; sampled with start
abort  input  1  synchronous abort; return to IDLE on next edge
rom_char_0..rom_char_3  input  4 each  caracter outputs of ROMs 0..3 (combinational in counter_caracter)
rom_len_0..rom_len_3  input  4 each  len_string of ROMs 0..3 = index of last character
counter_caracter  output  4  character index broadcast to all ROMs
char_out  output  4  selected character code
char_valid  output  1  char_out is valid and offered to the display
char_ready  input  1  display accepts char_out when high with char_valid
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after the last character of a non-looping message is accepted

Behaviour:
- Reset (async, active-high): state=IDLE, counter_caracter=0, char_valid=0, busy=0, done=0, sel_q=0, len_q=0, loop_q=0, dwell count=0.
- States: IDLE, SEND, DWELL, DONE.
- IDLE: on start=1 latch sel_q=msg_sel, loop_q=loop_en, len_q=rom_len[msg_sel]; counter_caracter=0; go SEND next cycle. start in any other state ignored.
- SEND: char_valid=1; char_out=rom_char[sel_q] (combinational from current counter_caracter, no latency). Hold char_out and counter stable until char_ready=1.
- Handshake (char_valid & char_ready at an edge):
  - counter_caracter < len_q: counter_caracter+1; go DWELL if DWELL_CYCLES>0, else stay in SEND.
  - counter_caracter == len_q and loop_q=0: go DONE.
  - counter_caracter == len_q and loop_q=1: counter_caracter=0; DWELL (or SEND if DWELL_CYCLES=0).
- DWELL: char_valid=0; count 0..DWELL_CYCLES-1, exactly DWELL_CYCLES cycles in DWELL, then SEND.
- DONE: done=1 for one cycle, char_valid=0, counter_caracter held at len_q; next state IDLE.
- char_out outside SEND: 0.
- len_q is fixed for the whole message; rom_len changes mid-message are ignored. len_q=0 means a one-character message; len_q=15 means 16 characters with no wrap of the 4-bit index beyond 15.
- abort=1 in any non-IDLE state: next state IDLE, counter_caracter=0, char_valid=0, no done pulse. abort has priority over a handshake in the same cycle; the character is treated as not sent.
- start and abort together in IDLE: abort wins and the state stays IDLE.
- Reset asserted mid-message: immediate return to reset values; no done.
- busy = (state != IDLE), registered with the state.
- All outputs change only on clk rising edge or reset; char_out is combinational from registered index/select.

Test Plan:
- Reset mid-SEND with char_valid=1 -> all outputs 0 and state IDLE without waiting for clk; a later start works normally.
- msg_sel=0 (ACEITO ROM, len 5), loop_en=0, DWELL_CYCLES=4, char_ready=1 -> char_out sequence 0,1,3,4,A,7 at indices 0..5, 4 dead cycles between characters, one done pulse, busy low the cycle after.
- Same message with char_ready low for 3 cycles on index 2 -> char_out=3 and counter_caracter=2 held stable for all 3 stall cycles; no character skipped or duplicated.
- loop_en=1, len 1, DWELL_CYCLES=0 -> indices 0,1,0,1,... back-to-back with char_valid continuously high; done never pulses; abort -> IDLE next edge, counter=0.
- len 0 ROM, loop_en=0 -> exactly one character accepted, then done; start pulsed while busy ignored (sel_q unchanged).
- abort and handshake in the same cycle on index 3 -> IDLE, no done; restart begins at index 0.
